// File: rtl/cpu_bus_decoder_pkg.sv
// Shared definitions for the aq32 CPU bus decoder: FSM encodings, latency field width,
// and the default slave map shared with aq32_top.
package cpu_bus_decoder_pkg;

    typedef logic [1:0] bus_state_t;

    localparam bus_state_t ST_IDLE  = 2'd0;
    localparam bus_state_t ST_COUNT = 2'd1;
    localparam bus_state_t ST_HS    = 2'd2;

    localparam int LAT_W = 2;

    // Slave 0 is the bootrom window (handshake), slave 1 the IO page (one read wait state).
    localparam int                    DEF_NUM_SLAVES = 2;
    localparam logic [2*32-1:0]       DEF_SLAVE_BASE = {32'hFFFF_F800, 32'hFFF0_0000};
    localparam logic [2*32-1:0]       DEF_SLAVE_MASK = {32'hFFFF_F800, 32'hFFF8_0000};
    localparam logic [2*LAT_W-1:0]    DEF_SLAVE_LAT  = {2'd1, 2'd0};
    localparam logic [1:0]            DEF_SLAVE_HS   = 2'b01;

    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bus_timeout_wdt.sv
// Saturating stall counter for handshake bus accesses.
// Only present when CPU_BUS_TIMEOUT_EN is defined.
`ifdef CPU_BUS_TIMEOUT_EN
module bus_timeout_wdt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               CNT_W   = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_tmo;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_tmo <= '0;
        end else if (i_enable && (r_tmo != LIMIT_V)) begin
            r_tmo <= r_tmo + CNT_W'(1);
        end
    end

    assign o_expired = (r_tmo == LIMIT_V);

endmodule
`endif

// File: rtl/cpu_bus_decoder.sv
// aq32 CPU-side bus decoder: address decode, fixed read wait states, s_wait handshake forwarding.
// Define CPU_BUS_TIMEOUT_EN to abort handshake accesses that stall for TIMEOUT_CYCLES.
//  state    | meaning
//  ST_IDLE  | no access, or cycle 0 of an access
//  ST_COUNT | fixed-latency read counting down its wait states
//  ST_HS    | handshake slave holding s_wait
module cpu_bus_decoder
    import cpu_bus_decoder_pkg::*;
#(
    parameter int                          NUM_SLAVES     = DEF_NUM_SLAVES,
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE     = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK     = DEF_SLAVE_MASK,
    parameter logic [NUM_SLAVES*LAT_W-1:0] SLAVE_LAT      = DEF_SLAVE_LAT,
    parameter logic [NUM_SLAVES-1:0]       SLAVE_HS       = DEF_SLAVE_HS,
    parameter int                          TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              cpu_addr,
    input  logic                     cpu_wren,
    input  logic                     cpu_strobe,
    output logic                     cpu_wait,
    output logic [31:0]              cpu_rddata,
    output logic                     cpu_error,
    output logic [NUM_SLAVES-1:0]    s_strobe,
    input  logic [NUM_SLAVES-1:0]    s_wait,
    input  logic [NUM_SLAVES*32-1:0] s_rddata
);

    generate
        if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
            $error("cpu_bus_decoder: NUM_SLAVES must be 1..8");
        end
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("cpu_bus_decoder: TIMEOUT_CYCLES must be 2..65535");
        end
    endgenerate

    logic                  w_hit_any;
    logic                  w_sel_hs;
    logic                  w_sel_wait;
    logic [LAT_W-1:0]      w_sel_lat;
    logic [31:0]           w_sel_rddata;
    logic [NUM_SLAVES-1:0] w_sel_oh;

    // Scan high to low so the lowest matching index wins on overlap.
    always_comb begin
        w_hit_any    = 1'b0;
        w_sel_hs     = 1'b0;
        w_sel_wait   = 1'b0;
        w_sel_lat    = '0;
        w_sel_rddata = '0;
        w_sel_oh     = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (addr_hit(cpu_addr, SLAVE_BASE[i*32 +: 32], SLAVE_MASK[i*32 +: 32])) begin
                w_hit_any    = 1'b1;
                w_sel_hs     = SLAVE_HS[i];
                w_sel_wait   = s_wait[i];
                w_sel_lat    = SLAVE_LAT[i*LAT_W +: LAT_W];
                w_sel_rddata = s_rddata[i*32 +: 32];
                w_sel_oh     = '0;
                w_sel_oh[i]  = 1'b1;
            end
        end
    end

    bus_state_t            r_state;
    bus_state_t            w_state_nxt;
    logic [LAT_W-1:0]      r_cnt;
    logic [LAT_W-1:0]      w_cnt_nxt;
    logic                  w_wait;
    logic                  w_error;
    logic                  w_abort;
    logic [NUM_SLAVES-1:0] w_strobe;

    // A dropped cpu_strobe outside IDLE falls through to the defaults: back to IDLE, counter cleared.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_wait      = 1'b0;
        w_error     = 1'b0;
        w_strobe    = '0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_strobe) begin
                    if (!w_hit_any) begin
                        w_error = 1'b1;
                    end else begin
                        w_strobe = w_sel_oh;
                        if (w_sel_hs) begin
                            w_wait = w_sel_wait;
                            if (w_sel_wait) w_state_nxt = ST_HS;
                        end else if (!cpu_wren && (w_sel_lat != '0)) begin
                            w_wait      = 1'b1;
                            w_cnt_nxt   = w_sel_lat - LAT_W'(1);
                            w_state_nxt = ST_COUNT;
                        end
                    end
                end
            end
            ST_COUNT: begin
                if (cpu_strobe) begin
                    w_strobe = w_sel_oh;
                    if (r_cnt != '0) begin
                        w_wait      = 1'b1;
                        w_cnt_nxt   = r_cnt - LAT_W'(1);
                        w_state_nxt = ST_COUNT;
                    end
                end
            end
            ST_HS: begin
                if (cpu_strobe) begin
                    if (w_abort) begin
                        w_error = 1'b1;
                    end else begin
                        w_strobe = w_sel_oh;
                        w_wait   = w_sel_wait;
                        if (w_sel_wait) w_state_nxt = ST_HS;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef CPU_BUS_TIMEOUT_EN
    logic w_hs_cycle;
    logic w_tmo_expired;

    assign w_hs_cycle = cpu_strobe && w_hit_any && w_sel_hs &&
                        ((r_state == ST_IDLE) || (r_state == ST_HS));

    bus_timeout_wdt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_state_nxt != ST_HS),
        .i_enable  (w_hs_cycle && w_wait),
        .o_expired (w_tmo_expired)
    );

    assign w_abort = (r_state == ST_HS) && w_tmo_expired;
`else
    assign w_abort = 1'b0;
`endif

    assign cpu_wait   = !reset && w_wait;
    assign cpu_error  = !reset && w_error;
    assign s_strobe   = reset ? '0 : w_strobe;
    assign cpu_rddata = (!reset && cpu_strobe && w_hit_any && !w_wait) ? w_sel_rddata : 32'h0;

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Randomized bench for cpu_bus_decoder against an access-level reference model.
// Honours CPU_BUS_TIMEOUT_EN the same way the design does.
module tb_cpu_bus_decoder;
    import cpu_bus_decoder_pkg::*;

    localparam int NS  = 4;
    localparam int TMO = 16;

    // Slots 0/1 are the aq32 default map; slots 2/3 overlap to exercise lowest-index priority.
    localparam logic [NS*32-1:0] P_BASE = {32'h2000_0000, 32'h2000_0000, 32'hFFFF_F800, 32'hFFF0_0000};
    localparam logic [NS*32-1:0] P_MASK = {32'hF000_0000, 32'hFF00_0000, 32'hFFFF_F800, 32'hFFF8_0000};
    localparam logic [NS*2-1:0]  P_LAT  = {2'd2, 2'd3, 2'd1, 2'd3};
    localparam logic [NS-1:0]    P_HS   = 4'b0001;

    // Reference map as plain tables.
    logic [31:0] m_base [NS] = '{32'hFFF0_0000, 32'hFFFF_F800, 32'h2000_0000, 32'h2000_0000};
    logic [31:0] m_mask [NS] = '{32'hFFF8_0000, 32'hFFFF_F800, 32'hFF00_0000, 32'hF000_0000};
    int          m_lat  [NS] = '{3, 1, 3, 2};
    bit          m_hs   [NS] = '{1'b1, 1'b0, 1'b0, 1'b0};

    logic             clk;
    logic             reset;
    logic [31:0]      cpu_addr;
    logic             cpu_wren;
    logic             cpu_strobe;
    logic             cpu_wait;
    logic [31:0]      cpu_rddata;
    logic             cpu_error;
    logic [NS-1:0]    s_strobe;
    logic [NS-1:0]    s_wait;
    logic [NS*32-1:0] s_rddata;

    int n_vec;
    int n_err;

    cpu_bus_decoder #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE     (P_BASE),
        .SLAVE_MASK     (P_MASK),
        .SLAVE_LAT      (P_LAT),
        .SLAVE_HS       (P_HS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wren   (cpu_wren),
        .cpu_strobe (cpu_strobe),
        .cpu_wait   (cpu_wait),
        .cpu_rddata (cpu_rddata),
        .cpu_error  (cpu_error),
        .s_strobe   (s_strobe),
        .s_wait     (s_wait),
        .s_rddata   (s_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_wait, input logic exp_err,
                                 input logic [NS-1:0] exp_stb, input logic [31:0] exp_rd);
        chk({tag, ".wait"},   32'(cpu_wait),  32'(exp_wait));
        chk({tag, ".error"},  32'(cpu_error), 32'(exp_err));
        chk({tag, ".strobe"}, 32'(s_strobe),  32'(exp_stb));
        chk({tag, ".rddata"}, cpu_rddata,     exp_rd);
    endtask

    function automatic int ref_sel(input logic [31:0] a);
        int s;
        s = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((a & m_mask[i]) == m_base[i]) s = i;
        end
        return s;
    endfunction

    // One access from cycle 0 to completion. hs_waits = cycles the selected
    // handshake slave holds s_wait; ignored for other slaves.
    task automatic run_access(input string tag, input logic [31:0] addr, input logic wr,
                              input int hs_waits);
        int            sel;
        int            nw;
        bit            abort;
        logic [NS-1:0] exp_stb;
        logic [31:0]   exp_rd;
        sel   = ref_sel(addr);
        abort = 1'b0;
        if (sel < 0) begin
            nw = 0;
        end else if (m_hs[sel]) begin
            nw = hs_waits;
`ifdef CPU_BUS_TIMEOUT_EN
            if (hs_waits >= TMO) begin
                nw    = TMO;
                abort = 1'b1;
            end
`endif
        end else begin
            nw = wr ? 0 : m_lat[sel];
        end
        for (int c = 0; c <= nw; c++) begin
            cpu_addr   = addr;
            cpu_wren   = wr;
            cpu_strobe = 1'b1;
            s_rddata   = {$urandom, $urandom, $urandom, $urandom};
            s_wait     = NS'($urandom);
            if (sel >= 0 && m_hs[sel]) s_wait[sel] = (c < hs_waits);
            #4;
            exp_stb = '0;
            if (sel >= 0 && !(abort && c == nw)) exp_stb[sel] = 1'b1;
            exp_rd = (sel >= 0 && c == nw) ? s_rddata[sel*32 +: 32] : 32'h0;
            check_outputs(tag, (c < nw), (sel < 0) || (abort && c == nw), exp_stb, exp_rd);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_cycle(input string tag);
        cpu_strobe = 1'b0;
        cpu_addr   = $urandom;
        cpu_wren   = 1'($urandom);
        s_wait     = NS'($urandom);
        s_rddata   = {$urandom, $urandom, $urandom, $urandom};
        #4;
        check_outputs(tag, 1'b0, 1'b0, '0, 32'h0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 4))
            0:       a = 32'hFFF0_0000 | ($urandom & 32'h0007_FFFF);
            1:       a = 32'hFFFF_F800 | ($urandom & 32'h0000_07FF);
            2:       a = 32'h2000_0000 | ($urandom & 32'h00FF_FFFF);
            3:       a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
            default: a = $urandom;
        endcase
        return a;
    endfunction

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        cpu_strobe = 1'b1;
        cpu_addr   = 32'hFFFF_F800;
        cpu_wren   = 1'b0;
        s_wait     = '1;
        s_rddata   = {4{32'hDEAD_BEEF}};
        @(posedge clk);
        #1;
        @(posedge clk);
        #4;
        check_outputs("reset", 1'b0, 1'b0, '0, 32'h0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        cpu_strobe = 1'b0;

        run_access("io_read",      32'hFFFF_F800, 1'b0, 0);
        run_access("io_write",     32'hFFFF_F804, 1'b1, 0);
        run_access("rom_hs3",      32'hFFF0_0010, 1'b0, 3);
        run_access("unmapped",     32'h0000_1000, 1'b0, 0);
        run_access("rom_hs0",      32'hFFF0_0020, 1'b0, 0);
        run_access("ovl_lo",       32'h2000_1234, 1'b0, 0);
        run_access("ovl_hi",       32'h2100_0000, 1'b0, 0);
        run_access("ovl_wr",       32'h2000_0008, 1'b1, 0);
        idle_cycle("idle");

        // Stuck handshake slave: aborts under the timeout build, otherwise waits it out.
        run_access("rom_stuck",    32'hFFF0_0000, 1'b0, 20);
        run_access("after_stuck",  32'hFFFF_F800, 1'b0, 0);
        run_access("rom_edge",     32'hFFF0_0004, 1'b0, TMO);
        run_access("rom_edge_m1",  32'hFFF0_0004, 1'b0, TMO - 1);
        // The stall counter must restart for each handshake access.
        run_access("rom_10a",      32'hFFF0_0008, 1'b0, 10);
        run_access("rom_10b",      32'hFFF0_0008, 1'b1, 10);

        // Reset in the middle of a fixed-latency read.
        cpu_addr   = 32'h2000_0040;
        cpu_wren   = 1'b0;
        cpu_strobe = 1'b1;
        #4;
        chk("rst_mid.c0_wait", 32'(cpu_wait), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #4;
        check_outputs("rst_mid.in_reset", 1'b0, 1'b0, '0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_access("rst_mid.retry", 32'h2000_0040, 1'b0, 0);

        // Strobe dropped mid-count and mid-handshake: next access starts from scratch.
        cpu_addr   = 32'h2000_0000;
        cpu_wren   = 1'b0;
        cpu_strobe = 1'b1;
        #4;
        chk("drop_cnt.c0_wait", 32'(cpu_wait), 32'd1);
        @(posedge clk);
        #1;
        idle_cycle("drop_cnt.idle");
        run_access("drop_cnt.retry", 32'h2000_0000, 1'b0, 0);

        cpu_addr   = 32'hFFF0_0000;
        cpu_strobe = 1'b1;
        s_wait     = '1;
        #4;
        chk("drop_hs.c0_wait", 32'(cpu_wait), 32'd1);
        @(posedge clk);
        #1;
        idle_cycle("drop_hs.idle");
        run_access("drop_hs.next", 32'hFFFF_F800, 1'b0, 0);

        for (int k = 0; k < 300; k++) begin
            int hw;
            hw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20))
                                             : int'($urandom_range(0, 4));
            run_access("rand", rand_addr(), 1'($urandom), hw);
            if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
